exit_report_uart: RTL and testbench

EXIT_REPORT_UART -- requirements
Module: exit_report_uart

---
 rtl/exit_report_uart.sv | 163 ++++++++++++++++
 tb/tb_exit_report_uart.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/exit_report_uart.sv
// Reports program exit / illegal-instruction events as 11-byte ASCII lines
// ("E"/"I" + 8 uppercase hex digits + CR LF) on a UART 8N1 transmitter.
module exit_report_uart #(
  parameter int CLK_DIV = 87
) (
  input  logic        clk_core_slow_i,
  input  logic        rst_n,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_value_i,
  input  logic        illegal_insn_i,
  input  logic [31:0] instr_addr_i,
  output logic        uart_tx_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam logic [1:0]  S_IDLE  = 2'd0;
  localparam logic [1:0]  S_START = 2'd1;
  localparam logic [1:0]  S_DATA  = 2'd2;
  localparam logic [1:0]  S_STOP  = 2'd3;
  localparam logic [15:0] DIV_M1  = 16'(CLK_DIV - 1);
  localparam logic [3:0]  LAST_BYTE = 4'd10;

  logic        exit_q, ill_q;
  logic        exit_seen, ill_seen;
  logic        exit_pend, ill_pend;
  logic [31:0] exit_buf, ill_buf;
  logic        exit_evt, ill_evt;

  logic [1:0]  state;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [3:0]  byte_idx;
  logic        sel_ill;
  logic        tx;
  logic        done;

  logic        msg_end, launch;
  logic [31:0] msg_word, msg_sh;
  logic [2:0]  nib_sel, nxt_bit;
  logic [3:0]  nib;
  logic [7:0]  hex_chr, cur_byte;

  // Each event type fires once per reset: the seen flag masks later edges.
  assign exit_evt = exit_valid_i   & ~exit_q & ~exit_seen;
  assign ill_evt  = illegal_insn_i & ~ill_q  & ~ill_seen;

  assign msg_end = (state == S_STOP) && (cnt == 16'd0) && (byte_idx == LAST_BYTE);
  // A pending message starts from IDLE or straight out of the previous final STOP.
  assign launch  = (exit_pend | ill_pend) && ((state == S_IDLE) || msg_end);
  assign nxt_bit = bit_idx + 3'd1;

  always_comb begin
    msg_word = sel_ill ? ill_buf : exit_buf;
    nib_sel  = 3'(4'd8 - byte_idx);
    msg_sh   = msg_word >> {nib_sel, 2'b00};
    nib      = msg_sh[3:0];
    hex_chr  = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    case (byte_idx)
      4'd0:    cur_byte = sel_ill ? 8'h49 : 8'h45;
      4'd9:    cur_byte = 8'h0D;
      4'd10:   cur_byte = 8'h0A;
      default: cur_byte = hex_chr;
    endcase
  end

  always_ff @(posedge clk_core_slow_i or negedge rst_n) begin
    if (!rst_n) begin
      exit_q    <= 1'b0;
      ill_q     <= 1'b0;
      exit_seen <= 1'b0;
      ill_seen  <= 1'b0;
      exit_pend <= 1'b0;
      ill_pend  <= 1'b0;
      exit_buf  <= '0;
      ill_buf   <= '0;
    end else begin
      exit_q <= exit_valid_i;
      ill_q  <= illegal_insn_i;
      if (exit_evt) begin
        exit_seen <= 1'b1;
        exit_buf  <= exit_value_i;
      end
      if (ill_evt) begin
        ill_seen <= 1'b1;
        ill_buf  <= instr_addr_i;
      end
      // Exit wins arbitration, so an illegal launch only happens with no exit pending.
      exit_pend <= exit_evt | (exit_pend & ~launch);
      ill_pend  <= ill_evt  | (ill_pend & ~(launch & ~exit_pend));
    end
  end

  always_ff @(posedge clk_core_slow_i or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      sel_ill  <= 1'b0;
      tx       <= 1'b1;
      done     <= 1'b0;
    end else begin
      if (msg_end && !sel_ill) done <= 1'b1;
      if (launch) begin
        state    <= S_START;
        cnt      <= DIV_M1;
        bit_idx  <= '0;
        byte_idx <= '0;
        sel_ill  <= ~exit_pend;
        tx       <= 1'b0;
      end else begin
        case (state)
          S_START: begin
            if (cnt == 16'd0) begin
              state   <= S_DATA;
              cnt     <= DIV_M1;
              bit_idx <= '0;
              tx      <= cur_byte[0];
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
          S_DATA: begin
            if (cnt == 16'd0) begin
              cnt <= DIV_M1;
              if (bit_idx == 3'd7) begin
                state <= S_STOP;
                tx    <= 1'b1;
              end else begin
                bit_idx <= nxt_bit;
                tx      <= cur_byte[nxt_bit];
              end
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
          S_STOP: begin
            if (cnt == 16'd0) begin
              if (byte_idx != LAST_BYTE) begin
                state    <= S_START;
                cnt      <= DIV_M1;
                bit_idx  <= '0;
                byte_idx <= byte_idx + 4'd1;
                tx       <= 1'b0;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign uart_tx_o = tx;
  assign busy_o    = (state != S_IDLE);
  assign done_o    = done;

endmodule

// File: tb/tb_exit_report_uart.sv
// Directed bench for exit_report_uart at CLK_DIV=4: a UART receiver model
// decodes the line, and vectors compare bytes, busy cycles and done.
module tb_exit_report_uart;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        exit_valid = 1'b0;
  logic [31:0] exit_value = '0;
  logic        illegal = 1'b0;
  logic [31:0] addr = '0;
  logic        uart_tx, busy, done;

  int n_chk = 0;
  int n_err = 0;

  exit_report_uart #(.CLK_DIV(DIV)) dut (
    .clk_core_slow_i(clk),
    .rst_n          (rst_n),
    .exit_valid_i   (exit_valid),
    .exit_value_i   (exit_value),
    .illegal_insn_i (illegal),
    .instr_addr_i   (addr),
    .uart_tx_o      (uart_tx),
    .busy_o         (busy),
    .done_o         (done)
  );

  always #5 clk = ~clk;

  int busy_cnt = 0;
  always @(negedge clk) if (busy === 1'b1) busy_cnt <= busy_cnt + 1;

  // Receiver model: owned entirely by this process.
  logic [7:0] rx_mem [0:255];
  int         rx_n = 0;
  int         rx_ferr = 0;
  logic [7:0] rx_b;
  bit         rx_ab;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && uart_tx === 1'b0) begin
        rx_b  = '0;
        rx_ab = 1'b0;
        for (int k = 1; k <= 9*DIV + 1; k++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) begin
            rx_ab = 1'b1;
            break;
          end
          if (k > DIV && (k % DIV) == 1) begin
            if ((k - 1) / DIV - 1 < 8) rx_b[(k - 1) / DIV - 1] = uart_tx;
            else if (uart_tx !== 1'b1) rx_ferr++;
          end
        end
        if (!rx_ab && rx_n < 256) begin
          rx_mem[rx_n] = rx_b;
          rx_n++;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_msg(input string name, input int base, input int nb,
                           input logic [0:21][7:0] exp);
    chk({name, "/nbytes"}, 32'(rx_n - base), 32'(nb));
    for (int k = 0; k < nb; k++)
      if (base + k < 256) chk($sformatf("%s/byte%0d", name, k), {24'h0, rx_mem[base + k]}, {24'h0, exp[k]});
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    exit_valid = 1'b0;
    illegal = 1'b0;
    #1;
    chk("reset/tx", {31'h0, uart_tx}, 32'h1);
    chk("reset/busy", {31'h0, busy}, 32'h0);
    chk("reset/done", {31'h0, done}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    string          name;
    logic           ex;
    logic [31:0]    val;
    logic           il;
    logic [31:0]    ad;
    int             nb;
    logic [0:21][7:0] exp;
    int             busy;
    logic           done;
  } vec_t;

  vec_t tbl [5];
  logic [0:21][7:0] e;
  int base, bbase;

  initial begin
    tbl[0] = '{"exit_2a", 1'b1, 32'h0000002A, 1'b0, 32'h0, 11,
               {8'h45, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h32, 8'h41, 8'h0D, 8'h0A, 88'h0},
               440, 1'b1};
    tbl[1] = '{"ill_1f4", 1'b0, 32'h0, 1'b1, 32'h000001F4, 11,
               {8'h49, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h31, 8'h46, 8'h34, 8'h0D, 8'h0A, 88'h0},
               440, 1'b0};
    tbl[2] = '{"both", 1'b1, 32'hDEADBEEF, 1'b1, 32'h00000080, 22,
               {8'h45, 8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A,
                8'h49, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h38, 8'h30, 8'h0D, 8'h0A},
               880, 1'b1};
    tbl[3] = '{"exit_9af0", 1'b1, 32'h9AF05C31, 1'b0, 32'h0, 11,
               {8'h45, 8'h39, 8'h41, 8'h46, 8'h30, 8'h35, 8'h43, 8'h33, 8'h31, 8'h0D, 8'h0A, 88'h0},
               440, 1'b1};
    tbl[4] = '{"ill_ffff", 1'b0, 32'h0, 1'b1, 32'hFFFFFFFF, 11,
               {8'h49, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h0D, 8'h0A, 88'h0},
               440, 1'b0};

    for (int v = 0; v < 5; v++) begin
      reset_dut();
      base  = rx_n;
      bbase = busy_cnt;
      @(negedge clk);
      exit_value = tbl[v].val;
      addr       = tbl[v].ad;
      exit_valid = tbl[v].ex;
      illegal    = tbl[v].il;
      @(negedge clk);
      illegal = 1'b0;
      repeat (1000) @(negedge clk);
      check_msg(tbl[v].name, base, tbl[v].nb, tbl[v].exp);
      chk({tbl[v].name, "/busy_cycles"}, 32'(busy_cnt - bbase), 32'(tbl[v].busy));
      chk({tbl[v].name, "/done"}, {31'h0, done}, {31'h0, tbl[v].done});
    end

    // Start latency, then reset in the middle of byte 3 with exit still high.
    reset_dut();
    @(negedge clk);
    exit_value = 32'h13579BDF;
    exit_valid = 1'b1;
    @(negedge clk);
    chk("lat/tx_edgeN", {31'h0, uart_tx}, 32'h1);
    chk("lat/busy_edgeN", {31'h0, busy}, 32'h0);
    @(negedge clk);
    chk("lat/tx_edgeN1", {31'h0, uart_tx}, 32'h0);
    chk("lat/busy_edgeN1", {31'h0, busy}, 32'h1);
    repeat (128) @(posedge clk);
    #2;
    chk("midrst/busy_before", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midrst/tx", {31'h0, uart_tx}, 32'h1);
    chk("midrst/busy", {31'h0, busy}, 32'h0);
    repeat (4) @(negedge clk);
    base = rx_n;
    rst_n = 1'b1;
    repeat (1000) @(negedge clk);
    e = {8'h45, 8'h31, 8'h33, 8'h35, 8'h37, 8'h39, 8'h42, 8'h44, 8'h46, 8'h0D, 8'h0A, 88'h0};
    check_msg("midrst/restart", base, 11, e);
    chk("midrst/done", {31'h0, done}, 32'h1);

    // Repeated illegal pulses and a long exit level each report only once.
    reset_dut();
    base = rx_n;
    @(negedge clk);
    addr = 32'h10;
    illegal = 1'b1;
    @(negedge clk);
    illegal = 1'b0;
    exit_value = 32'h1234ABCD;
    exit_valid = 1'b1;
    repeat (99) @(negedge clk);
    addr = 32'h20;
    illegal = 1'b1;
    repeat (2) @(negedge clk);
    illegal = 1'b0;
    repeat (400) @(negedge clk);
    addr = 32'h30;
    illegal = 1'b1;
    @(negedge clk);
    illegal = 1'b0;
    repeat (497) @(negedge clk);
    exit_valid = 1'b0;
    repeat (50) @(negedge clk);
    exit_valid = 1'b1;
    repeat (400) @(negedge clk);
    e = {8'h49, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h31, 8'h30, 8'h0D, 8'h0A,
         8'h45, 8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
    check_msg("once", base, 22, e);
    chk("once/done", {31'h0, done}, 32'h1);
    chk("once/idle", {31'h0, busy}, 32'h0);

    chk("stop_bits", 32'(rx_ferr), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
